// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared cpu constants and fetch state enum
package instr_fetch_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  // Redirect targets may carry junk in the byte-offset bits; fetches are word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - memory read bus and decoder handshake of the fetch stage
interface instr_fetch_if;

  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [31:0] instr_word;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        active;

  // Fetch unit side.
  modport master (
    output avm_address, avm_read, instr_word, instr_valid, pc, active,
    input  avm_waitrequest, avm_readdata, instr_ready, redirect, redirect_target
  );

  // Memory / decoder side.
  modport slave (
    input  avm_address, avm_read, instr_word, instr_valid, pc, active,
    output avm_waitrequest, avm_readdata, instr_ready, redirect, redirect_target
  );

endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch FSM with delayed-branch redirect and halt on jr $0
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  fetch_state_t state_q;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_word_q;
  logic         pending_q;
  logic [31:0]  pend_target_q;
  logic         avm_read_q;
  logic         instr_valid_q;
  logic         active_q;
  logic [31:0]  fetch_pc_d;

  // Address of the fetch after the current accept: a pending redirect wins over the sequential pc.
  always_comb begin
    fetch_pc_d = fetch_pc_q + 32'd4;
    if (pending_q) begin
      fetch_pc_d = pend_target_q;
    end
  end

  // Fetch FSM; every bus-facing output is a register so reset drops them immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_VECTOR;
      pc_q          <= RESET_VECTOR;
      instr_word_q  <= 32'h0;
      pending_q     <= 1'b0;
      pend_target_q <= 32'h0;
      avm_read_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      active_q      <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q    <= REQ;
          avm_read_q <= 1'b1;
        end
        REQ: begin
          if (!bus.avm_waitrequest) begin
            instr_word_q  <= bus.avm_readdata;
            pc_q          <= fetch_pc_q;
            fetch_pc_q    <= fetch_pc_d;
            pending_q     <= 1'b0;
            avm_read_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            if (bus.redirect) begin
              pending_q     <= 1'b1;
              pend_target_q <= word_align(bus.redirect_target);
            end
            // fetch_pc already reflects any earlier redirect, so jr $0 halts after its delay slot.
            if (fetch_pc_q == HALT_ADDR) begin
              active_q <= 1'b0;
              state_q  <= HALT;
            end else begin
              avm_read_q <= 1'b1;
              state_q    <= REQ;
            end
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= HALT;
        end
      endcase
    end
  end

  assign bus.avm_address = fetch_pc_q;
  assign bus.avm_read    = avm_read_q;
  assign bus.instr_word  = instr_word_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc          = pc_q;
  assign bus.active      = active_q;

endmodule
